// File: rtl/orv32s_mem_pkg.sv
// rtl/orv32s_mem_pkg.sv - shared types and widths for the orv32s memory arbiter
package orv32s_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } mem_arb_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } mem_owner_e;

    localparam int MEM_LINE_W = 64;
    localparam int MEM_LANE_W = 32;
    localparam int MEM_LINE_BE_W = MEM_LINE_W / 8;
    localparam int MEM_LANE_BE_W = MEM_LANE_W / 8;

endpackage

// File: rtl/orv32s_mem_lane.sv
// rtl/orv32s_mem_lane.sv - 32-bit lane to 64-bit line packing and unpacking
module orv32s_mem_lane
    import orv32s_mem_pkg::*;
(
    input  logic                     pack_sel,
    input  logic [MEM_LANE_W-1:0]    wdata,
    input  logic [MEM_LANE_BE_W-1:0] be,
    output logic [MEM_LINE_W-1:0]    line_wdata,
    output logic [MEM_LINE_BE_W-1:0] line_be,
    input  logic                     unpack_sel,
    input  logic [MEM_LINE_W-1:0]    line_rdata,
    output logic [MEM_LANE_W-1:0]    rdata
);

    // Store data goes to both lanes; only the enabled bytes of the chosen lane get written.
    always_comb begin
        line_wdata = {wdata, wdata};
        line_be    = pack_sel ? {be, {MEM_LANE_BE_W{1'b0}}} : {{MEM_LANE_BE_W{1'b0}}, be};
        rdata      = unpack_sel ? line_rdata[MEM_LINE_W-1:MEM_LANE_W] : line_rdata[MEM_LANE_W-1:0];
    end

endmodule

// File: rtl/orv32s_mem_arb.sv
// rtl/orv32s_mem_arb.sv - fetch/LSU arbiter onto one 64-bit memory port; optional MEM_ARB_STARVE_GUARD_EN
module orv32s_mem_arb
    import orv32s_mem_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int ADDR_W     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_req_i,
    input  logic [ADDR_W-1:0]        i_addr_i,
    input  logic                     i_flush_i,
    output logic                     i_gnt_o,
    output logic [MEM_LINE_W-1:0]    i_line_o,
    output logic                     i_valid_o,
    input  logic                     d_req_i,
    input  logic                     d_we_i,
    input  logic [ADDR_W-1:0]        d_addr_i,
    input  logic [MEM_LANE_W-1:0]    d_wdata_i,
    input  logic [MEM_LANE_BE_W-1:0] d_be_i,
    output logic                     d_gnt_o,
    output logic [MEM_LANE_W-1:0]    d_rdata_o,
    output logic                     d_valid_o,
    output logic                     m_req_o,
    output logic                     m_we_o,
    output logic [ADDR_W-1:0]        m_addr_o,
    output logic [MEM_LINE_W-1:0]    m_wdata_o,
    output logic [MEM_LINE_BE_W-1:0] m_be_o,
    input  logic                     m_ready_i,
    input  logic                     m_rvalid_i,
    input  logic [MEM_LINE_W-1:0]    m_rdata_i
);

    mem_arb_state_e           state_q;
    mem_arb_state_e           state_d;
    mem_owner_e               owner_q;
    logic [ADDR_W-4:0]        line_addr_q;
    logic                     lane_q;
    logic                     we_q;
    logic [MEM_LINE_W-1:0]    wdata_q;
    logic [MEM_LINE_BE_W-1:0] be_q;
    logic                     drop_q;
    logic                     i_valid_q;
    logic                     d_valid_q;
    logic [MEM_LINE_W-1:0]    i_line_q;
    logic [MEM_LANE_W-1:0]    d_rdata_q;

    logic                     arb_en;
    logic                     i_eligible;
    logic                     i_win;
    logic                     d_win;
    logic                     flush_hit;
    logic [MEM_LINE_W-1:0]    pack_wdata;
    logic [MEM_LINE_BE_W-1:0] pack_be;
    logic [MEM_LANE_W-1:0]    unpack_rdata;

    // Fetch addresses are line aligned and load/store lane width comes from byte enables.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr_i[2:0], d_addr_i[1:0]};

    orv32s_mem_lane u_lane (
        .pack_sel   (d_addr_i[2]),
        .wdata      (d_wdata_i),
        .be         (d_be_i),
        .line_wdata (pack_wdata),
        .line_be    (pack_be),
        .unpack_sel (lane_q),
        .line_rdata (m_rdata_i),
        .rdata      (unpack_rdata)
    );

    // Arbitration only happens in IDLE and never while reset is held.
    assign arb_en     = (state_q == IDLE) && !rst;
    assign i_eligible = i_req_i && !i_flush_i;
    assign flush_hit  = i_flush_i && (owner_q == OWN_I);

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_q;
    logic             starved;

    assign starved = (starve_q >= STARVE_LIM);

    // Data wins unless fetch has lost STARVE_MAX arbitrations in a row.
    always_comb begin
        i_win = 1'b0;
        d_win = 1'b0;
        if (arb_en) begin
            if (starved && i_eligible) begin
                i_win = 1'b1;
            end else begin
                d_win = d_req_i;
                i_win = i_eligible && !d_req_i;
            end
        end
    end

    // Count consecutive arbitrations where fetch was waiting and data took the port.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
        end else if (arb_en) begin
            if (i_win || !i_req_i) begin
                starve_q <= '0;
            end else if (d_win && !starved) begin
                starve_q <= starve_q + 1'b1;
            end
        end
    end
`else
    localparam int starve_max_unused = STARVE_MAX;

    // Strict priority: data always beats fetch.
    always_comb begin
        d_win = arb_en && d_req_i;
        i_win = arb_en && i_eligible && !d_req_i;
    end
`endif

    assign i_gnt_o = i_win;
    assign d_gnt_o = d_win;

    // Next-state logic for the single-outstanding transaction sequence.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (i_win || d_win) state_d = REQ;
            REQ:     if (m_ready_i) state_d = WAIT;
            WAIT:    if (m_rvalid_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the granted request, track flush drops and register responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q     <= OWN_I;
            line_addr_q <= '0;
            lane_q      <= 1'b0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            be_q        <= '0;
            drop_q      <= 1'b0;
            i_valid_q   <= 1'b0;
            d_valid_q   <= 1'b0;
            i_line_q    <= '0;
            d_rdata_q   <= '0;
        end else begin
            i_valid_q <= 1'b0;
            d_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (d_win) begin
                        owner_q     <= OWN_D;
                        line_addr_q <= d_addr_i[ADDR_W-1:3];
                        lane_q      <= d_addr_i[2];
                        we_q        <= d_we_i;
                        wdata_q     <= pack_wdata;
                        be_q        <= pack_be;
                        drop_q      <= 1'b0;
                    end else if (i_win) begin
                        owner_q     <= OWN_I;
                        line_addr_q <= i_addr_i[ADDR_W-1:3];
                        lane_q      <= 1'b0;
                        we_q        <= 1'b0;
                        wdata_q     <= '0;
                        be_q        <= '1;
                        drop_q      <= 1'b0;
                    end
                end
                REQ: begin
                    if (flush_hit) drop_q <= 1'b1;
                end
                WAIT: begin
                    if (flush_hit) drop_q <= 1'b1;
                    if (m_rvalid_i) begin
                        if (owner_q == OWN_I) begin
                            // A flush in the response cycle cancels it as well.
                            if (!(drop_q || i_flush_i)) begin
                                i_valid_q <= 1'b1;
                                i_line_q  <= m_rdata_i;
                            end
                        end else begin
                            d_valid_q <= 1'b1;
                            d_rdata_q <= unpack_rdata;
                        end
                    end
                end
                default: begin
                    drop_q <= 1'b0;
                end
            endcase
        end
    end

    assign m_req_o   = (state_q == REQ);
    assign m_we_o    = we_q;
    assign m_addr_o  = {line_addr_q, 3'b000};
    assign m_wdata_o = wdata_q;
    assign m_be_o    = be_q;
    assign i_valid_o = i_valid_q;
    assign i_line_o  = i_line_q;
    assign d_valid_o = d_valid_q;
    assign d_rdata_o = d_rdata_q;

endmodule

// File: tb/tb_orv32s_mem_arb.sv
// tb/tb_orv32s_mem_arb.sv - scoreboard bench for orv32s_mem_arb
module tb_orv32s_mem_arb;

    logic        clk;
    logic        rst;
    logic        i_req_i;
    logic [31:0] i_addr_i;
    logic        i_flush_i;
    logic        i_gnt_o;
    logic [63:0] i_line_o;
    logic        i_valid_o;
    logic        d_req_i;
    logic        d_we_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic [3:0]  d_be_i;
    logic        d_gnt_o;
    logic [31:0] d_rdata_o;
    logic        d_valid_o;
    logic        m_req_o;
    logic        m_we_o;
    logic [31:0] m_addr_o;
    logic [63:0] m_wdata_o;
    logic [7:0]  m_be_o;
    logic        m_ready_i;
    logic        m_rvalid_i;
    logic [63:0] m_rdata_i;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [7:0]  be;
        logic [63:0] wdata;
    } req_t;

    req_t        exp_req[$];
    logic [63:0] exp_i[$];
    logic [32:0] exp_d[$];

    int          n_assert = 0;
    int          n_fail   = 0;
    int          n_ival   = 0;
    int          n_dval   = 0;
    logic        mem_en;
    int          mem_wait;
    logic [63:0] mem_line;

    orv32s_mem_arb #(.STARVE_MAX(4), .ADDR_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_req_i    (i_req_i),
        .i_addr_i   (i_addr_i),
        .i_flush_i  (i_flush_i),
        .i_gnt_o    (i_gnt_o),
        .i_line_o   (i_line_o),
        .i_valid_o  (i_valid_o),
        .d_req_i    (d_req_i),
        .d_we_i     (d_we_i),
        .d_addr_i   (d_addr_i),
        .d_wdata_i  (d_wdata_i),
        .d_be_i     (d_be_i),
        .d_gnt_o    (d_gnt_o),
        .d_rdata_o  (d_rdata_o),
        .d_valid_o  (d_valid_o),
        .m_req_o    (m_req_o),
        .m_we_o     (m_we_o),
        .m_addr_o   (m_addr_o),
        .m_wdata_o  (m_wdata_o),
        .m_be_o     (m_be_o),
        .m_ready_i  (m_ready_i),
        .m_rvalid_i (m_rvalid_i),
        .m_rdata_i  (m_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_req(input logic [31:0] a, input logic we, input logic [7:0] be, input logic [63:0] wd);
        req_t r;
        r.addr = a; r.we = we; r.be = be; r.wdata = wd;
        exp_req.push_back(r);
    endtask

    task automatic wait_done();
        int k;
        for (k = 0; k < 30; k++) begin
            @(negedge clk); #3;
            if (exp_req.size() == 0 && exp_i.size() == 0 && exp_d.size() == 0) break;
        end
        check("drain_timeout", 64'(k < 30), 64'd1);
    endtask

    // Memory model: accepts a request immediately, answers mem_wait cycles after acceptance.
    initial begin : responder
        int   phase;
        int   wcnt;
        req_t r;
        phase = 0; wcnt = 0;
        m_ready_i = 1'b0; m_rvalid_i = 1'b0; m_rdata_i = '0;
        forever begin
            @(negedge clk);
            m_ready_i  = 1'b0;
            m_rvalid_i = 1'b0;
            if (rst || !mem_en) begin
                phase = 0;
            end else if (phase == 0) begin
                if (m_req_o) begin
                    m_ready_i = 1'b1;
                    phase = 1;
                    wcnt = mem_wait;
                    if (exp_req.size() == 0) begin
                        check("m_req_spurious", {63'd0, m_req_o}, 64'd0);
                    end else begin
                        r = exp_req.pop_front();
                        check("m_addr", 64'(m_addr_o), 64'(r.addr));
                        check("m_we", 64'(m_we_o), 64'(r.we));
                        check("m_be", 64'(m_be_o), 64'(r.be));
                        check("m_wdata", m_wdata_o, r.wdata);
                    end
                end
            end else begin
                if (wcnt == 0) begin
                    m_rvalid_i = 1'b1;
                    m_rdata_i = mem_line;
                    phase = 0;
                end else begin
                    wcnt--;
                end
            end
        end
    end

    // Response monitor: every valid pulse must match the head of its scoreboard queue.
    initial begin : monitor
        logic [63:0] ei;
        logic [32:0] ed;
        forever begin
            @(negedge clk); #2;
            if (i_valid_o === 1'b1) begin
                n_ival++;
                if (exp_i.size() == 0) check("i_valid_spurious", {63'd0, i_valid_o}, 64'd0);
                else begin
                    ei = exp_i.pop_front();
                    check("i_line", i_line_o, ei);
                end
            end
            if (d_valid_o === 1'b1) begin
                n_dval++;
                if (exp_d.size() == 0) check("d_valid_spurious", {63'd0, d_valid_o}, 64'd0);
                else begin
                    ed = exp_d.pop_front();
                    if (ed[32]) check("d_rdata", 64'(d_rdata_o), 64'(ed[31:0]));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1);
    end

    initial begin : stim
        int          k;
        int          nd;
        int          ni;
        int          g;
        int          ival0;
        int          dval0;
        logic [31:0] seq;

        rst = 1'b1; mem_en = 1'b1; mem_wait = 0; mem_line = '0;
        i_req_i = 1'b0; i_addr_i = '0; i_flush_i = 1'b0;
        d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_wdata_i = '0; d_be_i = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        check("rst_m_req", 64'(m_req_o), 64'd0);
        check("rst_m_we", 64'(m_we_o), 64'd0);
        check("rst_gnts", 64'({i_gnt_o, d_gnt_o}), 64'd0);
        check("rst_valids", 64'({i_valid_o, d_valid_o}), 64'd0);
        check("rst_m_addr", 64'(m_addr_o), 64'd0);
        check("rst_m_wdata", m_wdata_o, 64'd0);
        check("rst_m_be", 64'(m_be_o), 64'd0);
        check("rst_i_line", i_line_o, 64'd0);
        check("rst_d_rdata", 64'(d_rdata_o), 64'd0);
        rst = 1'b0;

        // Fetch only, zero-wait latency.
        @(negedge clk);
        i_req_i = 1'b1; i_addr_i = 32'h0000_1004; mem_line = 64'h1111_2222_3333_4444;
        push_req(32'h1000, 1'b0, 8'hFF, 64'd0);
        exp_i.push_back(64'h1111_2222_3333_4444);
        #1;
        check("c0_i_gnt", 64'(i_gnt_o), 64'd1);
        check("c0_d_gnt", 64'(d_gnt_o), 64'd0);
        @(negedge clk);
        i_req_i = 1'b0;
        #1;
        check("c1_m_req", 64'(m_req_o), 64'd1);
        check("c1_m_addr", 64'(m_addr_o), 64'h1000);
        check("c1_m_be", 64'(m_be_o), 64'hFF);
        @(negedge clk); #1;
        check("c2_m_req", 64'(m_req_o), 64'd0);
        check("c2_i_valid", 64'(i_valid_o), 64'd0);
        @(negedge clk); #3;
        check("c3_i_valid", 64'(i_valid_o), 64'd1);
        check("c3_i_line", i_line_o, 64'h1111_2222_3333_4444);
        wait_done();

        // Load from the upper lane.
        @(negedge clk);
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h2004; d_be_i = 4'hF; d_wdata_i = '0;
        mem_line = 64'hAAAA_BBBB_CCCC_DDDD;
        push_req(32'h2000, 1'b0, 8'hF0, 64'd0);
        exp_d.push_back({1'b1, 32'hAAAA_BBBB});
        #1;
        check("ld_d_gnt", 64'(d_gnt_o), 64'd1);
        @(negedge clk);
        d_req_i = 1'b0;
        wait_done();

        // Store to the lower lane, half-word enables.
        @(negedge clk);
        d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h2000; d_be_i = 4'b0011; d_wdata_i = 32'h1234_5678;
        mem_line = '0;
        push_req(32'h2000, 1'b1, 8'h03, 64'h1234_5678_1234_5678);
        exp_d.push_back({1'b0, 32'd0});
        #1;
        check("st_d_gnt", 64'(d_gnt_o), 64'd1);
        @(negedge clk);
        d_req_i = 1'b0; d_we_i = 1'b0;
        wait_done();

        // Simultaneous requests: data first, fetch three cycles later.
        @(negedge clk);
        i_req_i = 1'b1; i_addr_i = 32'h1008;
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h2000; d_be_i = 4'hF; d_wdata_i = '0;
        mem_line = 64'h0123_4567_89AB_CDEF;
        push_req(32'h2000, 1'b0, 8'h0F, 64'd0);
        exp_d.push_back({1'b1, 32'h89AB_CDEF});
        #1;
        check("both_d_gnt", 64'(d_gnt_o), 64'd1);
        check("both_i_gnt", 64'(i_gnt_o), 64'd0);
        for (k = 1; k < 7; k++) begin
            @(negedge clk);
            d_req_i = 1'b0;
            #1;
            if (i_gnt_o) break;
        end
        check("fetch_after_data_cycle", 64'(k), 64'd3);
        if (k < 7) begin
            push_req(32'h1008, 1'b0, 8'hFF, 64'd0);
            exp_i.push_back(64'h0123_4567_89AB_CDEF);
        end
        @(negedge clk);
        i_req_i = 1'b0;
        wait_done();

        // Flush while the fetch waits on a slow memory.
        mem_wait = 3;
        @(negedge clk);
        i_req_i = 1'b1; i_addr_i = 32'h1010; mem_line = 64'hDEAD_BEEF_0000_0001;
        push_req(32'h1010, 1'b0, 8'hFF, 64'd0);
        ival0 = n_ival;
        #1;
        check("fl_i_gnt", 64'(i_gnt_o), 64'd1);
        @(negedge clk);
        i_req_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        i_flush_i = 1'b1;
        @(negedge clk);
        i_flush_i = 1'b0;
        repeat (5) @(negedge clk);
        #3;
        check("fl_no_i_valid", 64'(n_ival - ival0), 64'd0);
        check("fl_rvalid_consumed", 64'(exp_req.size()), 64'd0);
        mem_wait = 0;

        // Flush in IDLE blocks a fetch grant.
        @(negedge clk);
        i_req_i = 1'b1; i_addr_i = 32'h1018; i_flush_i = 1'b1;
        #1;
        check("idle_flush_blocks", 64'(i_gnt_o), 64'd0);
        @(negedge clk);
        i_flush_i = 1'b0;
        mem_line = 64'hCAFE_F00D_1234_0000;
        push_req(32'h1018, 1'b0, 8'hFF, 64'd0);
        exp_i.push_back(64'hCAFE_F00D_1234_0000);
        #1;
        check("post_flush_i_gnt", 64'(i_gnt_o), 64'd1);
        @(negedge clk);
        i_req_i = 1'b0;
        wait_done();

        // Both requests held continuously.
        @(negedge clk);
        mem_line = 64'h5555_6666_7777_8888;
        i_req_i = 1'b1; i_addr_i = 32'h4000;
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h3000; d_be_i = 4'hF; d_wdata_i = '0;
        nd = 0; ni = 0; g = 0; seq = '0;
        for (int c = 0; c < 60; c++) begin
            #1;
            if (d_gnt_o) begin
                push_req(32'h3000, 1'b0, 8'h0F, 64'd0);
                exp_d.push_back({1'b1, 32'h7777_8888});
                nd++;
                if (g < 32) seq[g] = 1'b0;
                g++;
            end
            if (i_gnt_o) begin
                push_req(32'h4000, 1'b0, 8'hFF, 64'd0);
                exp_i.push_back(64'h5555_6666_7777_8888);
                ni++;
                if (g < 32) seq[g] = 1'b1;
                g++;
            end
            @(negedge clk);
        end
        i_req_i = 1'b0; d_req_i = 1'b0;
        wait_done();
`ifdef MEM_ARB_STARVE_GUARD_EN
        check("starve_d_grants", 64'(nd), 64'd16);
        check("starve_i_grants", 64'(ni), 64'd4);
        check("starve_pattern", 64'(seq[9:0]), 64'b10_0001_0000);
`else
        check("strict_d_grants", 64'(nd), 64'd20);
        check("strict_i_grants", 64'(ni), 64'd0);
`endif

        // Reset while the request is stalled in REQ.
        mem_en = 1'b0;
        @(negedge clk);
        i_req_i = 1'b1; i_addr_i = 32'h1020; mem_line = 64'hFFFF_0000_FFFF_0000;
        #1;
        check("rr_i_gnt", 64'(i_gnt_o), 64'd1);
        @(negedge clk);
        i_req_i = 1'b0;
        #1;
        check("rr_in_req", 64'(m_req_o), 64'd1);
        rst = 1'b1;
        ival0 = n_ival; dval0 = n_dval;
        @(negedge clk); #1;
        check("rr_m_req", 64'(m_req_o), 64'd0);
        check("rr_m_addr", 64'(m_addr_o), 64'd0);
        check("rr_m_be", 64'(m_be_o), 64'd0);
        check("rr_m_we", 64'(m_we_o), 64'd0);
        check("rr_gnts", 64'({i_gnt_o, d_gnt_o}), 64'd0);
        rst = 1'b0;
        mem_en = 1'b1;
        repeat (6) @(negedge clk);
        #3;
        check("rr_no_valid", 64'((n_ival - ival0) + (n_dval - dval0)), 64'd0);
        check("rr_m_req_idle", 64'(m_req_o), 64'd0);

        check("end_req_queue", 64'(exp_req.size()), 64'd0);
        check("end_i_queue", 64'(exp_i.size()), 64'd0);
        check("end_d_queue", 64'(exp_d.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
